// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Purpose: shared types and constants for the instruction-fetch front end.
//   RESET_PC / INST_NOP : default reset PC and bubble instruction word
//   fetch_entry         : one buffered {pc, inst} pair
//   clog2()             : pointer width helper for the prefetch queue
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Purpose: registered prefetch queue of fetch_entry; head is always visible.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_data    write an entry at the tail
//   i_pop             consume the head (ignored when empty)
//   i_flush           empty the queue; wins over a same-cycle push
//   o_head            current head entry (undefined content when empty)
//   o_count           number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = clog2(DEPTH)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  fetch_entry i_data,
  output fetch_entry o_head,
  output logic [PW:0] o_count
);

  fetch_entry        r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push & ~i_flush;
  assign w_pop   = i_pop & (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // Storage needs no reset: entries are only observed through r_count.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // The issue credit rule must make a push into a full, non-draining queue impossible.
  always @(posedge i_clk) begin
    assert (i_rst || !(w_push && !w_pop && r_count == (PW+1)'(DEPTH)));
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Purpose: instruction-fetch front end. Owns the PC, issues reads to a
// synchronous Imem (data one cycle after request), buffers returns in a
// prefetch queue and presents one {pc, inst} per cycle to FI/ID.
// Optional feature macro: FETCH_PERF_EN (adds stall/flush counters).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pause                    ID stall, holds the presented entry
//   redirect_valid/_pc       taken branch/jump from ID (pc[1:0] forced to 0)
//   imem_req/_addr/_rdata    Imem request, address and returned word
//   out_valid/_pc/_inst      presented instruction (pc=0, INST_NOP when idle)
//   perf_stall_cnt           [FETCH_PERF_EN] cycles with out_valid & pause
//   perf_flush_cnt           [FETCH_PERF_EN] accepted redirects
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] INST_NOP = fetch_unit_pkg::INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  import fetch_unit_pkg::*;

  localparam int PW = clog2(DEPTH);

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_pending;
  logic [PW:0] w_count;
  fetch_entry  w_head;
  fetch_entry  w_push_data;
  logic        w_valid;
  logic        w_pop;
  logic        w_redirect;
  logic [PW+1:0] w_credit;

  assign w_valid    = (w_count != '0);
  assign w_pop      = w_valid & ~pause;
  assign w_redirect = redirect_valid & ~pause;

  // Entries held plus the one in flight, less the one leaving this cycle,
  // must stay below DEPTH so every return has a slot.
  assign w_credit = {1'b0, w_count} + (PW+2)'(r_pending) - (PW+2)'(w_pop);
  assign imem_req = ~rst & (w_credit < (PW+2)'(DEPTH));
  assign imem_addr = r_pc;

  assign w_push_data = '{pc: r_req_pc, inst: imem_rdata};

  // A redirect flushes the queue, which also drops a same-cycle return.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_pending),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_req_pc  <= RESET_PC;
      r_pending <= 1'b0;
    end else if (w_redirect) begin
      // Any request issued this cycle is killed by clearing pending.
      r_pc      <= redirect_pc & 32'hFFFF_FFFC;
      r_pending <= 1'b0;
    end else begin
      r_pending <= imem_req;
      if (imem_req) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + 32'd4;
      end
    end
  end

  assign out_valid = w_valid;
  assign out_pc    = w_valid ? w_head.pc   : 32'h0;
  assign out_inst  = w_valid ? w_head.inst : INST_NOP;

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_valid & pause) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect)      r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end: owns the PC, issues reads to the synchronous instruction memory and buffers returned words in a small prefetch queue.
- Presents one {pc, inst} pair per cycle to the FI/ID pipeline register.
- Honours the ID-stage pause, and applies branch/jump redirects from ID by flushing queued and in-flight fetches.
- Sits between Imem (upstream) and FI_ID (downstream), replacing the bare PC register at the top level.

Parameters:
- DEPTH, 2, prefetch queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INST_NOP, 32'h0000_0000, instruction word driven when no valid entry is available.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pause  in  1  ID stall; holds the current output entry.
- redirect_valid  in  1  ID resolved a taken branch/jump this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 0).
- imem_req  out  1  a fetch is issued this cycle at imem_addr.
- imem_addr  out  32  fetch address, driven from the registered PC.
- imem_rdata  in  32  Imem read data; valid exactly 1 cycle after the request.
- out_valid  out  1  out_pc/out_inst hold a valid instruction.
- out_pc  out  32  PC of the presented instruction.
- out_inst  out  32  presented instruction; INST_NOP when out_valid=0.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; queue empty; pending=0.
  - out_valid=0, out_pc=0, out_inst=INST_NOP; imem_req=0 during reset.
- pop = out_valid & ~pause. The head entry is consumed at the posedge.
- Issue rule: imem_req = ~rst & ((count + pending - pop) < DEPTH).
  - On issue: pending<=1, req_pc<=pc, pc<=pc+4.
  - 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
- Return: in the cycle after an issue, imem_rdata is pushed as {req_pc, imem_rdata} unless that request was killed.
- Queue:
  - Registered FIFO; out_* reflect the head entry.
  - Push and pop in the same cycle are allowed, including when count=DEPTH.
  - The credit rule guarantees no overflow; a push into a full queue is an assertion failure.
- Latency:
  - Request in cycle N → push at end of N+1 → out_valid in N+2.
  - Steady state with pause=0: 1 instruction/cycle.
  - First out_valid after rst falls: cycle 2.
- Pause:
  - Head held stable while pause=1.
  - Fetching continues until the credit limit is reached, then imem_req=0.
- Redirect:
  - Acts only when redirect_valid & ~pause; redirect_valid while pause=1 is ignored (ID will reassert).
  - At the posedge: queue flushed; in-flight request killed (its data is not pushed); pc<=redirect_pc & ~3.
  - No delay slot: the word after the branch is discarded.
  - Next cycle: out_valid=0 and the request is at the target. Target instruction out_valid 3 cycles after the redirect cycle.
- Redirect same cycle as a return: the return is discarded.
- Redirect same cycle as an issue: the issued request is killed; redirect wins the pc update.
- Reset mid-operation: state is unconditionally reinitialised; in-flight data the next cycle is dropped.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs:
  - perf_stall_cnt (32): counts cycles with out_valid & pause.
  - perf_flush_cnt (32): counts accepted redirects.
  - Both clear on rst and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - INST_NOP and RESET_PC constants.
  - fetch_entry typedef {pc[31:0], inst[31:0]}.
  - Queue pointer width function clog2(DEPTH).
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry with push, pop, flush, count, head outputs.
  - flush has priority over push; flush with simultaneous pop is legal.

Test Plan:
- Reset release, pause=0, Imem word at addr A = A+32'h100 → out_valid first in cycle 2; then pc 0,4,8,… with inst 0x100,0x104,… one per cycle.
- pause=1 for 5 cycles at out_pc=8 → out_pc/out_inst held at 8/0x108; imem_req drops once count+pending=DEPTH; after release, 12,16 follow without gaps or duplicates.
- Redirect at out_pc=8 to redirect_pc=0x43 → next cycle out_valid=0; 3 cycles after redirect out_pc=0x40; words at 0xC and 0x10 never presented.
- redirect_valid=1 with pause=1 → ignored; stream continues unchanged.
- Redirect to 32'hFFFF_FFFC → out_pc FFFF_FFFC, then 0x0 (wrap).
- rst asserted while a request is pending → data next cycle not pushed; after release, restart at RESET_PC; with FETCH_PERF_EN, counters read 0.
